max7219_rx_emu: RTL and testbench

Behavioural and synthesizable MAX7219 receiver emulator. It is the slave end of the 16-bit MAX7219 serial link. It samples the SPI stream (spi_clk, din, cs/LOAD) in the system clock domain, decodes each register write into an internal register file, and drives one multiplexed 8-digit 7-segment display directly. It is used for loopback self-checking of the MAX7219 transmitter on-board and for boards with no MAX7219 fitted.

---
 rtl/max7219_rx_emu.sv | 196 +++++++++++++++++++
 tb/tb_max7219_rx_emu.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_rx_emu.sv
// MAX7219 receiver emulator: samples the 16-bit serial link in the clk domain,
// decodes register writes and drives one multiplexed 8-digit 7-segment display.
module max7219_rx_emu #(
    parameter int SYNC_STAGES = 2,
    parameter int SCAN_DIV    = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       din,
    input  logic       cs,
    output logic       dout,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic [7:0] seg,
    output logic [7:0] dig_sel,
    output logic       shutdown,
    output logic [3:0] intensity
);
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SYNC_STAGES-1:0] spi_clk_sync, din_sync, cs_sync;
    logic spi_clk_s, din_s, cs_s;
    logic spi_clk_d, cs_d;
    logic spi_rise_q, cs_rise_q, cs_fall_q, cs_low_q, din_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            spi_clk_sync <= '0;
            din_sync     <= '0;
            cs_sync      <= '1;
        end else begin
            spi_clk_sync <= {spi_clk_sync[SYNC_STAGES-2:0], spi_clk};
            din_sync     <= {din_sync[SYNC_STAGES-2:0], din};
            cs_sync      <= {cs_sync[SYNC_STAGES-2:0], cs};
        end
    end

    assign spi_clk_s = spi_clk_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];

    // Edge flags are registered; cs_low_q holds cs as it was before this
    // cycle's edge so a spi_clk rise coinciding with the cs rise still shifts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            spi_clk_d  <= 1'b0;
            cs_d       <= 1'b1;
            spi_rise_q <= 1'b0;
            cs_rise_q  <= 1'b0;
            cs_fall_q  <= 1'b0;
            cs_low_q   <= 1'b0;
            din_q      <= 1'b0;
        end else begin
            spi_clk_d  <= spi_clk_s;
            cs_d       <= cs_s;
            spi_rise_q <= spi_clk_s & ~spi_clk_d;
            cs_rise_q  <= cs_s & ~cs_d;
            cs_fall_q  <= ~cs_s & cs_d;
            cs_low_q   <= ~cs_d;
            din_q      <= din_s;
        end
    end

    logic [15:0] sreg, sreg_nx;
    logic [4:0]  bit_cnt, cnt_nx;
    logic        shift_en, commit, bad_frame;

    always_comb begin
        shift_en  = spi_rise_q & cs_low_q;
        sreg_nx   = shift_en ? {sreg[14:0], din_q} : sreg;
        cnt_nx    = (shift_en && bit_cnt != 5'd31) ? bit_cnt + 5'd1 : bit_cnt;
        commit    = cs_rise_q && (cnt_nx == 5'd16);
        bad_frame = cs_rise_q && (cnt_nx != 5'd16) && (cnt_nx != 5'd0);
    end

    // wr_valid is a single-cycle notification with no back-pressure: the
    // register file is written on the same edge that raises it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg      <= '0;
            bit_cnt   <= '0;
            dout      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            sreg      <= sreg_nx;
            bit_cnt   <= cs_fall_q ? 5'd0 : cnt_nx;
            dout      <= sreg[15];
            wr_valid  <= commit;
            frame_err <= bad_frame;
            if (commit) begin
                wr_addr <= sreg_nx[11:8];
                wr_data <= sreg_nx[7:0];
            end
        end
    end

    logic [7:0] digit_q [8];
    logic [7:0] decode_q;
    logic [3:0] intensity_q;
    logic [2:0] scan_limit;
    logic       shut_q, test_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) digit_q[i] <= '0;
            decode_q    <= '0;
            intensity_q <= '0;
            scan_limit  <= '0;
            shut_q      <= 1'b0;
            test_q      <= 1'b0;
        end else if (commit) begin
            case (sreg_nx[11:8])
                4'h1, 4'h2, 4'h3, 4'h4,
                4'h5, 4'h6, 4'h7, 4'h8: digit_q[3'(sreg_nx[11:8] - 4'h1)] <= sreg_nx[7:0];
                4'h9:    decode_q    <= sreg_nx[7:0];
                4'hA:    intensity_q <= sreg_nx[3:0];
                4'hB:    scan_limit  <= sreg_nx[2:0];
                4'hC:    shut_q      <= sreg_nx[0];
                4'hF:    test_q      <= sreg_nx[0];
                default: ;
            endcase
        end
    end

    assign shutdown  = ~shut_q;
    assign intensity = intensity_q;

    logic [SCW-1:0] scan_cnt;
    logic [2:0]     scan_idx;

    // A scan_limit lowered below the live index forces a wrap at the next advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx >= scan_limit) ? 3'd0 : scan_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SCW'(1);
        end
    end

    function automatic logic [6:0] code_b(input logic [3:0] v);
        case (v)
            4'h0: code_b = 7'h7E;
            4'h1: code_b = 7'h30;
            4'h2: code_b = 7'h6D;
            4'h3: code_b = 7'h79;
            4'h4: code_b = 7'h33;
            4'h5: code_b = 7'h5B;
            4'h6: code_b = 7'h5F;
            4'h7: code_b = 7'h70;
            4'h8: code_b = 7'h7F;
            4'h9: code_b = 7'h7B;
            4'hA: code_b = 7'h01;
            4'hB: code_b = 7'h4F;
            4'hC: code_b = 7'h37;
            4'hD: code_b = 7'h0E;
            4'hE: code_b = 7'h67;
            default: code_b = 7'h00;
        endcase
    endfunction

    logic [7:0] cur_digit, seg_nx, dig_nx;

    always_comb begin
        cur_digit = digit_q[scan_idx];
        dig_nx    = ~(8'b1 << scan_idx);
        seg_nx    = cur_digit;
        if (test_q) begin
            seg_nx = 8'hFF;
        end else if (!shut_q) begin
            dig_nx = 8'hFF;
            seg_nx = 8'h00;
        end else if (decode_q[scan_idx]) begin
            seg_nx = {cur_digit[7], code_b(cur_digit[3:0])};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg     <= '0;
            dig_sel <= 8'hFF;
        end else begin
            seg     <= seg_nx;
            dig_sel <= dig_nx;
        end
    end
endmodule

// File: tb/tb_max7219_rx_emu.sv
// Directed bench for max7219_rx_emu: serial frames with hand-computed register
// and display expectations, checked on the falling clock edge.
module tb_max7219_rx_emu;
    localparam int SYNC_STAGES = 2;
    localparam int SCAN_DIV    = 256;
    localparam int HALF        = 4;
    localparam int LIMIT       = 3 * 8 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       spi_clk = 1'b0;
    logic       din = 1'b0;
    logic       cs = 1'b1;
    logic       dout, wr_valid, frame_err, shutdown;
    logic [3:0] wr_addr, intensity;
    logic [7:0] wr_data, seg, dig_sel;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    logic [3:0] cap_addr = '0;
    logic [7:0] cap_data = '0;

    max7219_rx_emu #(.SYNC_STAGES(SYNC_STAGES), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .din(din), .cs(cs),
        .dout(dout), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err), .seg(seg), .dig_sel(dig_sel),
        .shutdown(shutdown), .intensity(intensity)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Counts cycles with wr_valid high, so each frame must contribute exactly one.
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt   = wr_cnt + 1;
            cap_addr = wr_addr;
            cap_data = wr_data;
        end
        if (frame_err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din = val[i];
            wait_clk(HALF);
            spi_clk = 1'b1;
            wait_clk(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        cs = 1'b0;
        wait_clk(HALF);
        shift_bits(val, n);
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(12);
    endtask

    task automatic send_frame(input logic [15:0] f);
        send_bits({16'h0, f}, 16);
    endtask

    task automatic wait_digit(input int idx);
        logic [7:0] exp;
        int n;
        exp = ~(8'h1 << idx);
        n = 0;
        @(negedge clk);
        while (dig_sel != exp && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("dig_sel_reach", {24'h0, dig_sel}, {24'h0, exp});
    endtask

    task automatic wait_entry(input logic [7:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (dig_sel == exp && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        while (dig_sel != exp && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("dig_sel_entry", {24'h0, dig_sel}, {24'h0, exp});
    endtask

    initial begin
        int wr0, err0, n, bad;
        bit left, seen2;
        logic [15:0] m;
        logic [31:0] pat;

        // 1: reset values, then leave shutdown
        wait_clk(5);
        @(negedge clk);
        check("rst_dout", {31'h0, dout}, 32'h0);
        check("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
        check("rst_wr_data", {24'h0, wr_data}, 32'h0);
        check("rst_seg", {24'h0, seg}, 32'h0);
        check("rst_dig_sel", {24'h0, dig_sel}, 32'hFF);
        check("rst_shutdown", {31'h0, shutdown}, 32'h1);
        check("rst_intensity", {28'h0, intensity}, 32'h0);
        @(posedge clk);
        reset = 1'b1;
        wait_clk(4);
        send_frame(16'h0C01);
        check("t1_wr_cnt", wr_cnt, 1);
        check("t1_addr", {28'h0, cap_addr}, 32'hC);
        check("t1_data", {24'h0, cap_data}, 32'h01);
        check("t1_shutdown", {31'h0, shutdown}, 32'h0);

        // 2: Code-B decode and full-width scan period
        send_frame(16'h0B07);
        send_frame(16'h09FF);
        send_frame(16'h0103);
        send_frame(16'h0285);
        check("t2_wr_cnt", wr_cnt, 5);
        wait_digit(0);
        check("t2_seg_d0", {24'h0, seg}, 32'h79);
        wait_digit(1);
        check("t2_seg_d1", {24'h0, seg}, 32'hDB);
        wait_entry(8'hFE);
        n = 0;
        left = 1'b0;
        while (n < LIMIT) begin
            @(negedge clk);
            n++;
            if (dig_sel != 8'hFE) left = 1'b1;
            else if (left) break;
        end
        check("t2_scan_period", n, 8 * SCAN_DIV);

        // 3: raw digit and scan_limit lowered below the live index
        send_frame(16'h0900);
        send_frame(16'h0130);
        wait_digit(0);
        check("t3_seg_raw", {24'h0, seg}, 32'h30);
        wait_entry(8'hDF);
        send_frame(16'h0B02);
        n = 0;
        while (dig_sel == 8'hDF && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("t3_wrap_to_0", {24'h0, dig_sel}, 32'hFE);
        bad = 0;
        seen2 = 1'b0;
        for (int i = 0; i < 6 * SCAN_DIV; i++) begin
            @(negedge clk);
            if (dig_sel == 8'hFB) seen2 = 1'b1;
            else if (dig_sel != 8'hFE && dig_sel != 8'hFD) bad++;
        end
        check("t3_out_of_range", bad, 0);
        check("t3_seen_d2", {31'h0, seen2}, 32'h1);

        // 4: short and long frames, spi_clk activity with cs high
        wr0 = wr_cnt;
        err0 = err_cnt;
        send_bits(32'h0000_0C01, 12);
        send_bits(32'h0001_0C00, 17);
        check("t4_err_cnt", err_cnt, err0 + 2);
        check("t4_wr_cnt", wr_cnt, wr0);
        check("t4_shutdown", {31'h0, shutdown}, 32'h0);
        wait_digit(0);
        check("t4_seg_kept", {24'h0, seg}, 32'h30);
        din = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_clk(HALF);
            spi_clk = 1'b1;
            wait_clk(HALF);
            spi_clk = 1'b0;
        end
        din = 1'b0;
        wait_clk(10);
        @(negedge clk);
        check("t4_cs_high_dout", {31'h0, dout}, 32'h0);
        check("t4_cs_high_wr", wr_cnt, wr0);
        check("t4_cs_high_err", err_cnt, err0 + 2);

        // 5: test mode, shutdown, intensity, NOP
        send_frame(16'h0C00);
        @(negedge clk);
        check("t5_shutdown", {31'h0, shutdown}, 32'h1);
        check("t5_blank", {24'h0, dig_sel}, 32'hFF);
        send_frame(16'h0F01);
        wait_digit(1);
        check("t5_test_seg1", {24'h0, seg}, 32'hFF);
        wait_digit(2);
        check("t5_test_seg2", {24'h0, seg}, 32'hFF);
        send_frame(16'h0F00);
        @(negedge clk);
        check("t5_test_off_dig", {24'h0, dig_sel}, 32'hFF);
        check("t5_test_off_seg", {24'h0, seg}, 32'h00);
        send_frame(16'h0A0F);
        check("t5_intensity", {28'h0, intensity}, 32'hF);
        wr0 = wr_cnt;
        send_frame(16'h0000);
        check("t5_nop_wr", wr_cnt, wr0 + 1);
        check("t5_nop_addr", {28'h0, cap_addr}, 32'h0);
        check("t5_nop_intensity", {28'h0, intensity}, 32'hF);
        check("t5_nop_shutdown", {31'h0, shutdown}, 32'h1);

        // 6: reset mid-frame
        wr0 = wr_cnt;
        err0 = err_cnt;
        cs = 1'b0;
        wait_clk(HALF);
        shift_bits(32'h0000_00A5, 8);
        @(posedge clk);
        reset = 1'b0;
        cs = 1'b1;
        wait_clk(6);
        @(negedge clk);
        check("t6_rst_dig_sel", {24'h0, dig_sel}, 32'hFF);
        check("t6_rst_seg", {24'h0, seg}, 32'h00);
        check("t6_rst_shutdown", {31'h0, shutdown}, 32'h1);
        check("t6_rst_intensity", {28'h0, intensity}, 32'h0);
        check("t6_rst_wr_addr", {28'h0, wr_addr}, 32'h0);
        check("t6_rst_wr_data", {24'h0, wr_data}, 32'h0);
        check("t6_rst_dout", {31'h0, dout}, 32'h0);
        @(posedge clk);
        reset = 1'b1;
        wait_clk(20);
        check("t6_rst_no_wr", wr_cnt, wr0);
        check("t6_rst_no_err", err_cnt, err0);

        // 6: back-to-back frames separated by one bit time of cs high
        cs = 1'b0;
        wait_clk(HALF);
        shift_bits(32'h0000_0C01, 16);
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(2 * HALF);
        cs = 1'b0;
        wait_clk(HALF);
        shift_bits(32'h0000_0A05, 16);
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(12);
        check("t6_b2b_wr", wr_cnt, wr0 + 2);
        check("t6_b2b_shutdown", {31'h0, shutdown}, 32'h0);
        check("t6_b2b_intensity", {28'h0, intensity}, 32'h5);
        check("t6_b2b_addr", {28'h0, cap_addr}, 32'hA);
        check("t6_b2b_data", {24'h0, cap_data}, 32'h05);

        // 6: dout is din delayed by 16 shifts (sreg still holds 0x0A05)
        err0 = err_cnt;
        pat = 32'hA5C3_3C96;
        m = 16'h0A05;
        cs = 1'b0;
        wait_clk(HALF);
        for (int i = 31; i >= 0; i--) begin
            din = pat[i];
            wait_clk(HALF);
            spi_clk = 1'b1;
            wait_clk(HALF);
            spi_clk = 1'b0;
            wait_clk(HALF);
            @(negedge clk);
            m = {m[14:0], pat[i]};
            check("t6_dout", {31'h0, dout}, {31'h0, m[15]});
        end
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(12);
        check("t6_long_err", err_cnt, err0 + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
